// File: rtl/magic_nor_sequencer_pkg.sv
// Shared types and sizing for the MAGIC NOR sequencer: FSM states, instruction
// layout and the illegal-instruction rule.
package magic_pkg;

    function automatic int calc_cell_w(input int num_cells);
        return (num_cells > 1) ? $clog2(num_cells) : 1;
    endfunction

    function automatic int calc_pc_w(input int prog_depth);
        return (prog_depth > 1) ? $clog2(prog_depth) : 1;
    endfunction

    localparam int NUM_IN     = 7;
    localparam int NUM_CELLS  = 32;
    localparam int PROG_DEPTH = 32;
    localparam int CELL_W     = calc_cell_w(NUM_CELLS);
    localparam int PC_W       = calc_pc_w(PROG_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        EVAL,
        DONE
    } state_t;

    typedef struct packed {
        logic [CELL_W-1:0] dst;
        logic [CELL_W-1:0] srca;
        logic [CELL_W-1:0] srcb;
    } instr_t;

    function automatic logic idx_ok(input logic [CELL_W-1:0] idx);
        return ({1'b0, idx} < (CELL_W+1)'(NUM_CELLS));
    endfunction

    // A MAGIC gate cannot overwrite one of its own inputs in place.
    function automatic logic is_illegal(input instr_t ins);
        return (ins.dst == ins.srca) || (ins.dst == ins.srcb) ||
               !idx_ok(ins.dst) || !idx_ok(ins.srca) || !idx_ok(ins.srcb);
    endfunction

endpackage

// File: rtl/magic_nor_sequencer_if.sv
// Host-side bus of the NOR sequencer: program load, run handshake and result.
interface magic_nor_sequencer_if;
    import magic_pkg::*;

    logic                  prog_we;
    logic [PC_W-1:0]       prog_addr;
    logic [3*CELL_W-1:0]   prog_wdata;
    logic [PC_W:0]         prog_len;
    logic [CELL_W-1:0]     out_sel;
    logic                  start;
    logic [NUM_IN-1:0]     in_vec;
    logic                  busy;
    logic                  done;
    logic                  result;
    logic                  err;

    modport master (
        output prog_we, prog_addr, prog_wdata, prog_len, out_sel, start, in_vec,
        input  busy, done, result, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, prog_len, out_sel, start, in_vec,
        output busy, done, result, err
    );

endinterface

// File: rtl/magic_nor_sequencer_cell_array.sv
// Bit-cell row: parallel input load, one pre-set port, one NOR write port and
// three combinational read ports.
module magic_cell_array
    import magic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [NUM_IN-1:0] load_vec,
    input  logic              pre_en,
    input  logic [CELL_W-1:0] pre_addr,
    input  logic              wr_en,
    input  logic [CELL_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic [CELL_W-1:0] rd_a_addr,
    input  logic [CELL_W-1:0] rd_b_addr,
    input  logic [CELL_W-1:0] out_addr,
    output logic              rd_a,
    output logic              rd_b,
    output logic              out_bit
);

    logic [NUM_CELLS-1:0] cell_q;
    logic [NUM_CELLS-1:0] cell_d;

    always_comb begin
        // NOTE: start from the held value so every path assigns cell_d and no latch is inferred.
        cell_d = cell_q;
        if (load_en) cell_d[NUM_IN-1:0] = load_vec;
        if (pre_en)  cell_d[pre_addr]   = 1'b1;
        if (wr_en)   cell_d[wr_addr]    = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so all flops update together at the edge.
        if (!rst_n) cell_q <= '0;
        else        cell_q <= cell_d;
    end

    assign rd_a    = cell_q[rd_a_addr];
    assign rd_b    = cell_q[rd_b_addr];
    assign out_bit = cell_q[out_addr];

endmodule

// File: rtl/magic_nor_sequencer.sv
// MAGIC NOR-netlist sequencer: program RAM, FSM, pc and sticky err around the cell row.
// Optional MAGIC_INIT_CYCLE_EN adds a per-instruction output pre-set (INIT) cycle.
module magic_nor_sequencer
    import magic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    magic_nor_sequencer_if.slave  bus
);

    state_t            state_q,  state_d;
    logic [PC_W-1:0]   pc_q,     pc_d;
    logic [PC_W:0]     len_q,    len_d;
    logic [CELL_W-1:0] sel_q,    sel_d;
    logic [NUM_IN-1:0] vec_q,    vec_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              result_q, result_d;
    logic              err_q,    err_d;
`ifdef MAGIC_INIT_CYCLE_EN
    logic              illegal_q, illegal_d;
`endif

    instr_t            prog_q [PROG_DEPTH];
    instr_t            cur;
    logic              cur_ill;
    logic [PC_W:0]     len_clamped;

    logic              load_en, pre_en, wr_en;
    logic              rd_a, rd_b, out_bit;

    assign cur         = prog_q[pc_q];
    assign cur_ill     = is_illegal(cur);
    assign len_clamped = (bus.prog_len > (PC_W+1)'(PROG_DEPTH)) ?
                         (PC_W+1)'(PROG_DEPTH) : bus.prog_len;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        sel_d    = sel_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        err_d    = err_q;
`ifdef MAGIC_INIT_CYCLE_EN
        illegal_d = illegal_q;
`endif
        load_en  = 1'b0;
        pre_en   = 1'b0;
        wr_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    vec_d   = bus.in_vec;
                    len_d   = len_clamped;
                    sel_d   = bus.out_sel;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_en = 1'b1;
`ifdef MAGIC_INIT_CYCLE_EN
                state_d = (len_q == '0) ? DONE : INIT;
`else
                state_d = (len_q == '0) ? DONE : EVAL;
`endif
            end
`ifdef MAGIC_INIT_CYCLE_EN
            INIT: begin
                illegal_d = cur_ill;
                if (cur_ill) err_d  = 1'b1;
                else         pre_en = 1'b1;
                state_d = EVAL;
            end
`endif
            EVAL: begin
`ifdef MAGIC_INIT_CYCLE_EN
                wr_en = !illegal_q;
`else
                wr_en = !cur_ill;
                if (cur_ill) err_d = 1'b1;
`endif
                pc_d = pc_q + 1'b1;
                if ({1'b0, pc_q} == len_q - 1'b1) begin
                    state_d = DONE;
                end else begin
`ifdef MAGIC_INIT_CYCLE_EN
                    state_d = INIT;
`else
                    state_d = EVAL;
`endif
                end
            end
            DONE: begin
                result_d = out_bit;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            sel_q     <= '0;
            vec_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef MAGIC_INIT_CYCLE_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            sel_q     <= sel_d;
            vec_q     <= vec_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            err_q     <= err_d;
`ifdef MAGIC_INIT_CYCLE_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Writes land only in IDLE, so a same-cycle start runs the updated program.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the program store is cleared on reset, so a reset run needs a reload.
            for (int i = 0; i < PROG_DEPTH; i++) prog_q[i] <= '0;
        end else if (state_q == IDLE && bus.prog_we) begin
            prog_q[bus.prog_addr] <= instr_t'(bus.prog_wdata);
        end
    end

    magic_cell_array u_cells (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_vec  (vec_q),
        .pre_en    (pre_en),
        .pre_addr  (cur.dst),
        .wr_en     (wr_en),
        .wr_addr   (cur.dst),
        .wr_data   (~(rd_a | rd_b)),
        .rd_a_addr (cur.srca),
        .rd_b_addr (cur.srcb),
        .out_addr  (sel_q),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .out_bit   (out_bit)
    );

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule
